// File: rtl/digit_serial_adder.sv
// Digit-serial adder: one 3-bit slice adder reused per digit, LSB digit first.
// Optional saturation on final carry-out is enabled by defining DSA_SAT_EN.
module digit_serial_adder #(
    parameter int NDIGITS = 4,
    parameter int W       = 3 * NDIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic [1:0]   dbg_state_o
);

    localparam int KW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    logic [W-1:0]  a_shift;
    logic [W-1:0]  b_shift;
    logic [3:0]    slice_full;

    // Digit k of the latched operands shifted down to bit 0, then one 3-bit add.
    assign a_shift    = a_q >> (3 * int'(k_q));
    assign b_shift    = b_q >> (3 * int'(k_q));
    assign slice_full = {1'b0, a_shift[2:0]} + {1'b0, b_shift[2:0]} + {3'b000, carry_q};

    // Both ports use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both 1; ready never depends combinationally on valid.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[3*int'(k_q) +: 3] = slice_full[2:0];
                carry_d                 = slice_full[3];
                if (k_q == K_LAST) begin
                    cout_d  = slice_full[3];
`ifdef DSA_SAT_EN
                    if (slice_full[3]) begin
                        sum_d = '1;
                    end
`endif
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule
